// File: rtl/turn_request_conditioner_if.sv
// Button inputs and LEFT/RIGHT/mode request outputs of the turn request conditioner.
// The master drives the raw keys. The slave returns the decoded request levels.
interface turn_request_conditioner_if;
    logic       key_left_n;
    logic       key_right_n;
    logic       key_hazard_n;
    logic       LEFT;
    logic       RIGHT;
    logic [1:0] mode;

    modport master (
        output key_left_n, key_right_n, key_hazard_n,
        input  LEFT, RIGHT, mode
    );

    modport slave (
        input  key_left_n, key_right_n, key_hazard_n,
        output LEFT, RIGHT, mode
    );
endinterface

// File: rtl/turn_request_conditioner.sv
// Syncs and debounces three push-buttons into latched turn/hazard requests with auto-cancel.
// A clean press reaches LEFT/RIGHT DEB_CYCLES+3 edges after the raw edge. There is no backpressure: outputs are levels.
module turn_request_conditioner #(
    parameter int DEB_CYCLES     = 240000,
    parameter int DEB_W          = 18,
    parameter int TIMEOUT_CYCLES = 360000000,
    parameter int TO_W           = 29
) (
    input  logic                        clk,
    input  logic                        rst,
    turn_request_conditioner_if.slave   bus
);

    localparam int KL = 0;
    localparam int KR = 1;
    localparam int KH = 2;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_LEFT  = 2'b01,
        ST_RIGHT = 2'b10,
        ST_HAZ   = 2'b11
    } mode_e;

    logic [2:0]       w_raw_n;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_deb;
    logic [2:0]       r_deb_d;
    logic [2:0]       r_arm;
    logic [1:0]       r_vld;
    logic [DEB_W-1:0] r_cnt [3];
    logic [2:0]       w_press;

    mode_e            r_mode;
    mode_e            w_mode_nxt;
    logic [TO_W-1:0]  r_to;
    logic [TO_W-1:0]  w_to_nxt;
    logic             w_timeout;

    assign w_raw_n = {bus.key_hazard_n, bus.key_right_n, bus.key_left_n};

    // r_vld marks when r_sync2 holds a real input sample rather than its reset value.
    // A key is armed only once it has been seen released after reset,
    // so a key held through reset never produces a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_deb   <= '1;
            r_deb_d <= '1;
            r_arm   <= '0;
            r_vld   <= '0;
            for (int k = 0; k < 3; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_sync1 <= w_raw_n;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            r_vld   <= {r_vld[0], 1'b1};
            for (int k = 0; k < 3; k++) begin
                if (r_sync2[k] == r_deb[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == DEB_LAST) begin
                    r_deb[k] <= r_sync2[k];
                    r_cnt[k] <= '0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + DEB_W'(1);
                end
                if (r_vld[1] && r_sync2[k] && r_deb[k]) begin
                    r_arm[k] <= 1'b1;
                end
            end
        end
    end

    assign w_press = r_deb_d & ~r_deb & r_arm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= ST_OFF;
            r_to   <= '0;
        end else begin
            r_mode <= w_mode_nxt;
            r_to   <= w_to_nxt;
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        w_to_nxt   = r_to;
        w_timeout  = ((r_mode == ST_LEFT) || (r_mode == ST_RIGHT)) && (r_to == TO_LAST);

        if (w_press[KH]) begin
            w_mode_nxt = (r_mode == ST_HAZ) ? ST_OFF : ST_HAZ;
        end else if (w_press[KL] && w_press[KR]) begin
            w_mode_nxt = ST_HAZ;
        end else if (w_press[KL]) begin
            if (r_mode == ST_LEFT) begin
                w_mode_nxt = ST_OFF;
            end else if (r_mode != ST_HAZ) begin
                w_mode_nxt = ST_LEFT;
            end
        end else if (w_press[KR]) begin
            if (r_mode == ST_RIGHT) begin
                w_mode_nxt = ST_OFF;
            end else if (r_mode != ST_HAZ) begin
                w_mode_nxt = ST_RIGHT;
            end
        end else if (w_timeout) begin
            w_mode_nxt = ST_OFF;
        end

        // The counter restarts on any mode change, so LEFT_ON -> RIGHT_ON gets a full timeout.
        if ((w_mode_nxt != r_mode) || (w_mode_nxt == ST_OFF) || (w_mode_nxt == ST_HAZ)) begin
            w_to_nxt = '0;
        end else if (r_to != TO_LAST) begin
            w_to_nxt = r_to + TO_W'(1);
        end
    end

    // The state encoding is chosen so that bit 0 is LEFT and bit 1 is RIGHT.
    assign bus.mode  = r_mode;
    assign bus.LEFT  = r_mode[0];
    assign bus.RIGHT = r_mode[1];

endmodule

// File: tb/tb_turn_request_conditioner.sv
// Self-checking bench: directed scenarios plus random key activity against a cycle-level behavioural model.
// The model tracks debounce as "DEB consecutive differing samples" and timeout as "cycles since entry".
module tb_turn_request_conditioner;

    localparam int DEB = 4;
    localparam int TO  = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    turn_request_conditioner_if bus ();

    turn_request_conditioner #(
        .DEB_CYCLES     (DEB),
        .DEB_W          (3),
        .TIMEOUT_CYCLES (TO),
        .TO_W           (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [2:0] raw_n;
    assign raw_n = {bus.key_hazard_n, bus.key_right_n, bus.key_left_n};

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    int m_mode;
    int m_entry;
    bit m_deb   [3];
    bit m_deb_d [3];
    bit m_blk   [3];
    bit m_hist  [3][8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_entry = cyc;
        for (int k = 0; k < 3; k++) begin
            m_deb[k]   = 1'b1;
            m_deb_d[k] = 1'b1;
            m_blk[k]   = (raw_n[k] == 1'b0);
            for (int i = 0; i < 8; i++) m_hist[k][i] = 1'b1;
        end
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_step();
        bit p [3];
        int nm;
        bit stable;
        for (int k = 0; k < 3; k++) p[k] = m_deb_d[k] && !m_deb[k] && !m_blk[k];
        nm = m_mode;
        if (p[2])                nm = (m_mode == 3) ? 0 : 3;
        else if (p[0] && p[1])   nm = 3;
        else if (p[0]) begin
            if (m_mode == 1)      nm = 0;
            else if (m_mode != 3) nm = 1;
        end else if (p[1]) begin
            if (m_mode == 2)      nm = 0;
            else if (m_mode != 3) nm = 2;
        end else if ((m_mode == 1 || m_mode == 2) && (cyc - m_entry == TO)) begin
            nm = 0;
        end
        if (nm != m_mode) m_entry = cyc;
        m_mode = nm;
        // Debounced level flips once the two-cycle-delayed sample has disagreed for DEB cycles in a row.
        for (int k = 0; k < 3; k++) begin
            for (int i = 7; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
            m_hist[k][0] = raw_n[k];
            m_deb_d[k] = m_deb[k];
            stable = 1'b1;
            for (int i = 2; i <= DEB + 1; i++) if (m_hist[k][i] == m_deb[k]) stable = 1'b0;
            if (stable) begin
                m_deb[k] = !m_deb[k];
                if (m_deb[k]) m_blk[k] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        chk("mode",  32'(bus.mode),  32'(m_mode));
        chk("LEFT",  32'(bus.LEFT),  32'(m_mode == 1 || m_mode == 3));
        chk("RIGHT", 32'(bus.RIGHT), 32'(m_mode == 2 || m_mode == 3));
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic set_keys(input bit l, input bit r, input bit h);
        bus.key_left_n   = l;
        bus.key_right_n  = r;
        bus.key_hazard_n = h;
    endtask

    // A clean press: low for `hold` cycles, then released for `rel` cycles.
    task automatic press(input int k, input int hold, input int rel);
        if (k == 0) bus.key_left_n = 1'b0;
        if (k == 1) bus.key_right_n = 1'b0;
        if (k == 2) bus.key_hazard_n = 1'b0;
        run(hold);
        set_keys(1'b1, 1'b1, 1'b1);
        run(rel);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mode",  32'(bus.mode),  32'd0);
        chk("rst_LEFT",  32'(bus.LEFT),  32'd0);
        chk("rst_RIGHT", 32'(bus.RIGHT), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    int e;
    int seg [3];
    bit val [3];

    initial begin
        set_keys(1'b1, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("init_mode",  32'(bus.mode),  32'd0);
        chk("init_LEFT",  32'(bus.LEFT),  32'd0);
        chk("init_RIGHT", 32'(bus.RIGHT), 32'd0);
        run(5);

        // 1: latency, release ignored, toggle off
        bus.key_left_n = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 6) chk("t1_lat6", 32'(bus.LEFT), 32'd0);
            if (i == 7) chk("t1_lat7", 32'(bus.LEFT), 32'd1);
        end
        run(13);
        chk("t1_mode", 32'(bus.mode), 32'd1);
        chk("t1_right", 32'(bus.RIGHT), 32'd0);
        bus.key_left_n = 1'b1;
        run(10);
        chk("t1_rel", 32'(bus.mode), 32'd1);
        press(0, 8, 6);
        chk("t1_off", 32'(bus.mode), 32'd0);
        chk("t1_offL", 32'(bus.LEFT), 32'd0);

        // 2: bounce rejection, then a 5-cycle pulse is accepted
        for (int i = 0; i < 2; i++) begin
            bus.key_left_n = 1'b0; run(3);
            bus.key_left_n = 1'b1; run(3);
        end
        run(10);
        chk("t2_bounce", 32'(bus.mode), 32'd0);
        chk("t2_bounceL", 32'(bus.LEFT), 32'd0);
        press(0, 5, 10);
        chk("t2_pulse5", 32'(bus.mode), 32'd1);

        // 3: right from LEFT_ON, then timeout exactly TO cycles later
        bus.key_right_n = 1'b0;
        run(7);
        e = cyc;
        chk("t3_mode", 32'(bus.mode), 32'd2);
        chk("t3_L", 32'(bus.LEFT), 32'd0);
        chk("t3_R", 32'(bus.RIGHT), 32'd1);
        run(5);
        bus.key_right_n = 1'b1;
        run_to(e + TO - 1);
        chk("t3_pre_to", 32'(bus.mode), 32'd2);
        tick();
        chk("t3_to", 32'(bus.mode), 32'd0);

        // 4: simultaneous left+right gives hazard; left ignored; no timeout; hazard clears
        set_keys(1'b0, 1'b0, 1'b1);
        run(7);
        chk("t4_haz", 32'(bus.mode), 32'd3);
        run(5);
        set_keys(1'b1, 1'b1, 1'b1);
        run(200);
        chk("t4_noto", 32'(bus.mode), 32'd3);
        press(0, 8, 6);
        chk("t4_left_ign", 32'(bus.mode), 32'd3);
        press(2, 8, 6);
        chk("t4_haz_off", 32'(bus.mode), 32'd0);
        chk("t4_haz_offR", 32'(bus.RIGHT), 32'd0);

        // 5a: left press lands on the LEFT_ON timeout cycle
        e = cyc + 7;
        press(0, 8, 6);
        run_to(e + TO - 7);
        bus.key_left_n = 1'b0;
        run(6);
        chk("t5a_pre", 32'(bus.mode), 32'd1);
        tick();
        chk("t5a", 32'(bus.mode), 32'd0);
        run(4);
        bus.key_left_n = 1'b1;
        run(10);
        chk("t5a_hold", 32'(bus.mode), 32'd0);

        // 5b: left press lands on the RIGHT_ON timeout cycle; fresh timeout follows
        e = cyc + 7;
        press(1, 8, 6);
        run_to(e + TO - 7);
        bus.key_left_n = 1'b0;
        run(7);
        chk("t5b", 32'(bus.mode), 32'd1);
        run(5);
        bus.key_left_n = 1'b1;
        run_to(e + 2 * TO - 1);
        chk("t5b_pre_to", 32'(bus.mode), 32'd1);
        tick();
        chk("t5b_to", 32'(bus.mode), 32'd0);

        // 6: async reset with left held; held key ignored until released
        bus.key_left_n = 1'b0;
        run(10);
        chk("t6_on", 32'(bus.mode), 32'd1);
        reset_pulse();
        run(20);
        chk("t6_held", 32'(bus.mode), 32'd0);
        bus.key_left_n = 1'b1;
        run(10);
        press(0, 8, 6);
        chk("t6_repress", 32'(bus.mode), 32'd1);
        run(60);

        // Random key activity with short bounces and long holds mixed
        for (int k = 0; k < 3; k++) begin
            seg[k] = 1;
            val[k] = 1'b1;
        end
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 3; k++) begin
                seg[k]--;
                if (seg[k] == 0) begin
                    val[k] = !val[k];
                    seg[k] = (k == 2) ? $urandom_range(1, 30) : $urandom_range(1, 12);
                end
            end
            set_keys(val[0], val[1], val[2]);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/turn_request_conditioner.md
Name: turn_request_conditioner

Overview:
- Upstream input stage for the tail-light sequencer.
- Takes three raw momentary push-buttons (left, right, hazard; active-low on the board) and synchronizes and debounces each one.
- Converts the button presses into latched turn and hazard requests, with automatic turn cancel.
- Drives the LEFT/RIGHT level inputs the sequencer consumes: LEFT only = left turn, RIGHT only = right turn, both = hazard, neither = idle.

Parameters:
- DEB_CYCLES, 240000, clean-level stability time in clk cycles (20 ms at 12 MHz).
- DEB_W, 18, debounce counter width; must hold DEB_CYCLES-1.
- TIMEOUT_CYCLES, 360000000, turn auto-cancel time in clk cycles (30 s at 12 MHz).
- TO_W, 29, timeout counter width; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  input  1  system clock, 12 MHz
- rst  input  1  asynchronous reset, active-high
- key_left_n  input  1  raw left button, 0 = pressed, asynchronous
- key_right_n  input  1  raw right button, 0 = pressed, asynchronous
- key_hazard_n  input  1  raw hazard button, 0 = pressed, asynchronous
- LEFT  output  1  left request level to sequencer
- RIGHT  output  1  right request level to sequencer
- mode  output  2  00 OFF, 01 LEFT_ON, 10 RIGHT_ON, 11 HAZARD

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high; ports named clk and rst.
- Reset values:
  - Sync flops and debounced levels = 1 (released).
  - Debounce counters = 0; timeout counter = 0.
  - mode = OFF; LEFT = 0; RIGHT = 0.
- Reset asserted mid-operation aborts everything at once. No press event is generated on reset release, even if a key is held. A key held through reset must be released and pressed again to register.
- Per-key synchronizer: two flops.
- Per-key debounce:
  - Counter clears whenever the synchronized value equals the debounced value.
  - Counter increments while they differ.
  - When it differs and the counter = DEB_CYCLES-1, the debounced value takes the synchronized value and the counter clears.
  - Any bounce shorter than DEB_CYCLES cycles is rejected.
- Press event: debounced value goes 1->0. It is a one-cycle combinational strobe from the debounced value and its 1-cycle delayed copy. Release events are ignored.
- Latency: a clean raw press held stable changes LEFT/RIGHT exactly DEB_CYCLES+3 clk edges after the raw edge.
- Mode FSM transitions, evaluated each cycle in this priority:
  1. Hazard press: HAZARD -> OFF; any other state -> HAZARD.
  2. Left and right press in the same cycle: -> HAZARD from any state.
  3. Left press: LEFT_ON -> OFF; OFF or RIGHT_ON -> LEFT_ON; HAZARD ignores it.
  4. Right press: RIGHT_ON -> OFF; OFF or LEFT_ON -> RIGHT_ON; HAZARD ignores it.
  5. Timeout: in LEFT_ON/RIGHT_ON with the timeout counter = TIMEOUT_CYCLES-1 -> OFF.
  6. Otherwise hold.
- Timeout counter:
  - Clears on every mode change and in OFF/HAZARD.
  - Increments each cycle in LEFT_ON/RIGHT_ON.
  - A press in the same cycle as a timeout wins (priority above).
  - Switching LEFT_ON -> RIGHT_ON restarts the full timeout.
  - No wrap-around: the counter never exceeds TIMEOUT_CYCLES-1.
- Output decode, combinational from the mode register (glitch-free, single register source):
  - OFF: LEFT=0, RIGHT=0.
  - LEFT_ON: LEFT=1, RIGHT=0.
  - RIGHT_ON: LEFT=0, RIGHT=1.
  - HAZARD: LEFT=1, RIGHT=1.
- Holding a key indefinitely produces exactly one press event. No auto-repeat.

Test Plan:
(Bench uses DEB_CYCLES=4, DEB_W=3, TIMEOUT_CYCLES=50, TO_W=6.)
1. Reset, then a clean left press held 20 cycles -> LEFT rises exactly 7 edges after the raw falling edge; mode=01; RIGHT=0. Release has no effect. A second press -> mode=00, LEFT=0.
2. Left raw toggling 0/1/0/1 with 3-cycle pulses, then stable 1 -> no mode change, LEFT stays 0. A 5-cycle low pulse -> mode=01.
3. Right press in LEFT_ON -> mode=10, LEFT=0, RIGHT=1. With no further presses, mode=00 exactly 50 cycles after entering RIGHT_ON.
4. Left and right raw edges applied in the same cycle from OFF -> mode=11, LEFT=RIGHT=1. A later left press leaves mode=11. A hazard press -> mode=00. No timeout in HAZARD after 200 cycles.
5. A left press event arranged in the same cycle the timeout expires in LEFT_ON -> mode=00 via the toggle, and the timeout counter reads 0. Repeat in RIGHT_ON -> mode=01 with the timeout restarted (expires 50 cycles later).
6. Assert rst for 1 cycle while in LEFT_ON with left held -> LEFT=RIGHT=0 and mode=00 immediately (asynchronously). After release, the still-held key causes no event. Release plus re-press -> mode=01.
